pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage RV32 pipeline. Drives the stall and flush

---
 rtl/pipe_hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: arbitrates memory wait, mret,
// trap, taken branch and load-use, and keeps a stall counter and a busy watchdog.
module pipe_hazard_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             im_busy_i,
  input  logic             dm_busy_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_memread_i,
  input  logic             ex_br_taken_i,
  input  logic             irq_take_i,
  input  logic             mem_csr_ret_i,
  output logic             pc_write_o,
  output logic [1:0]       pc_sel_o,
  output logic             stall_ifid_o,
  output logic             stall_idex_o,
  output logic             stall_exmem_o,
  output logic             stall_memwb_o,
  output logic             flush_ifid_o,
  output logic             flush_idex_o,
  output logic             flush_exmem_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             timeout_o
);

  typedef enum logic [1:0] {S_RUN, S_MWAIT, S_REDIR, S_MWAIT_R} state_t;

  localparam logic [12:0]      TO_LIM  = {1'b0, TIMEOUT[11:0]};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [11:0]      r_wd;
  logic             r_timeout;

  logic       w_busy, w_load_use, w_hold, w_eval;
  logic       w_pc_write;
  logic [1:0] w_pc_sel;
  logic       w_fl_ifid, w_fl_idex, w_fl_exmem, w_st_ifid;

  assign w_busy     = im_busy_i | dm_busy_i;
  assign w_load_use = ex_memread_i && (ex_rd_i != 5'd0) &&
                      ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

  always_comb begin
    w_state_nxt = r_state;
    w_hold      = 1'b0;
    w_eval      = 1'b0;
    w_pc_write  = 1'b1;
    w_pc_sel    = 2'd0;
    w_fl_ifid   = 1'b0;
    w_fl_idex   = 1'b0;
    w_fl_exmem  = 1'b0;
    w_st_ifid   = 1'b0;

    case (r_state)
      S_RUN, S_MWAIT: begin
        if (w_busy) begin
          w_hold      = 1'b1;
          w_state_nxt = S_MWAIT;
        end else begin
          w_eval = 1'b1;
        end
      end
      S_REDIR: begin
        // Kill the wrong-path fetch; if memory stalls, the kill is owed until it releases.
        w_fl_ifid = 1'b1;
        if (w_busy) begin
          w_hold      = 1'b1;
          w_state_nxt = S_MWAIT_R;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        if (w_busy) begin
          w_hold = 1'b1;
        end else begin
          w_fl_ifid   = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
    endcase

    if (w_hold) w_pc_write = 1'b0;

    if (w_eval) begin
      w_state_nxt = S_RUN;
      if (mem_csr_ret_i) begin
        w_pc_sel    = 2'd3;
        w_fl_ifid   = 1'b1;
        w_fl_idex   = 1'b1;
        w_fl_exmem  = 1'b1;
        w_state_nxt = S_REDIR;
      end else if (irq_take_i) begin
        w_pc_sel    = 2'd2;
        w_fl_ifid   = 1'b1;
        w_fl_idex   = 1'b1;
        w_state_nxt = S_REDIR;
      end else if (ex_br_taken_i) begin
        w_pc_sel    = 2'd1;
        w_fl_ifid   = 1'b1;
        w_fl_idex   = 1'b1;
        w_state_nxt = S_REDIR;
      end else if (w_load_use) begin
        w_pc_write = 1'b0;
        w_st_ifid  = 1'b1;
        w_fl_idex  = 1'b1;
      end
    end
  end

  assign pc_write_o    = w_pc_write;
  assign pc_sel_o      = w_pc_sel;
  assign stall_ifid_o  = w_hold | w_st_ifid;
  assign stall_idex_o  = w_hold;
  assign stall_exmem_o = w_hold;
  assign stall_memwb_o = w_hold;
  assign flush_ifid_o  = w_fl_ifid;
  assign flush_idex_o  = w_fl_idex;
  assign flush_exmem_o = w_fl_exmem;
  assign stall_cnt_o   = r_stall_cnt;
  assign timeout_o     = r_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RUN;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (stall_ifid_o && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end
  end

  // Timeout fires on the edge that completes the TIMEOUT-th consecutive busy cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (!w_busy)               r_wd <= '0;
      else if (r_wd != 12'hFFF)  r_wd <= r_wd + 12'd1;
      if (w_busy && (({1'b0, r_wd} + 13'd1) >= TO_LIM)) r_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed + randomized bench for pipe_hazard_ctrl against an event-level reference model.
module tb_pipe_hazard_ctrl;
  localparam int CW = 8;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic im_busy, dm_busy, ex_memread, ex_br, irq, mret;
  logic [4:0] rs1, rs2, rd;
  logic pc_write, st_ifid, st_idex, st_exmem, st_memwb, fl_ifid, fl_idex, fl_exmem, tmo;
  logic [1:0] pc_sel;
  logic [CW-1:0] scnt;

  pipe_hazard_ctrl #(.CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .im_busy_i(im_busy), .dm_busy_i(dm_busy),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .ex_rd_i(rd), .ex_memread_i(ex_memread),
    .ex_br_taken_i(ex_br), .irq_take_i(irq), .mem_csr_ret_i(mret),
    .pc_write_o(pc_write), .pc_sel_o(pc_sel), .stall_ifid_o(st_ifid),
    .stall_idex_o(st_idex), .stall_exmem_o(st_exmem), .stall_memwb_o(st_memwb),
    .flush_ifid_o(fl_ifid), .flush_idex_o(fl_idex), .flush_exmem_o(fl_exmem),
    .stall_cnt_o(scnt), .timeout_o(tmo));

  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;

  // Reference model: "redirected last cycle" and "a wrong-path kill is still owed".
  bit   m_redir, m_owe, m_tmo;
  int   m_run, m_cnt;
  logic m_pcw;
  logic [1:0] m_sel;
  logic [3:0] m_st;   // {memwb, exmem, idex, ifid}
  logic [2:0] m_fl;   // {exmem, idex, ifid}

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    ntot++;
    assert (o === e) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
  endtask

  task automatic model_reset();
    m_redir = 0; m_owe = 0; m_tmo = 0; m_run = 0; m_cnt = 0;
  endtask

  task automatic drive(input bit im, input bit dm, input int r1, input int r2, input int d,
                       input bit mr, input bit br, input bit iq, input bit rt);
    im_busy = im; dm_busy = dm; rs1 = 5'(r1); rs2 = 5'(r2); rd = 5'(d);
    ex_memread = mr; ex_br = br; irq = iq; mret = rt;
  endtask

  // Called mid-cycle: check combinational outputs, advance the model, clock, check registers.
  task automatic step();
    bit busy, lu, kill;
    busy = im_busy | dm_busy;
    lu   = ex_memread && rd != 0 && (rd == rs1 || rd == rs2);
    kill = m_redir || m_owe;
    m_pcw = 1; m_sel = 0; m_st = 0; m_fl = 0;
    if (busy) begin
      m_pcw = 0; m_st = 4'hF; m_fl = {2'b00, m_redir};
    end else if (kill) m_fl = 3'b001;
    else if (mret)         begin m_sel = 3; m_fl = 3'b111; end
    else if (irq)          begin m_sel = 2; m_fl = 3'b011; end
    else if (ex_br)        begin m_sel = 1; m_fl = 3'b011; end
    else if (lu)           begin m_pcw = 0; m_st = 4'b0001; m_fl = 3'b010; end
    chk("pc_write", 32'(pc_write), 32'(m_pcw));
    chk("pc_sel",   32'(pc_sel),   32'(m_sel));
    chk("stalls",   32'({st_memwb, st_exmem, st_idex, st_ifid}), 32'(m_st));
    chk("flushes",  32'({fl_exmem, fl_idex, fl_ifid}), 32'(m_fl));
    m_owe   = busy && kill;
    m_redir = !busy && !kill && (mret || irq || ex_br);
    if (m_st != 0 && m_cnt < (1 << CW) - 1) m_cnt++;
    m_run = busy ? ((m_run < 4095) ? m_run + 1 : m_run) : 0;
    if (busy && m_run >= TO) m_tmo = 1;
    @(posedge clk); #1;
    chk("stall_cnt", 32'(scnt), 32'(m_cnt));
    chk("timeout",   32'(tmo),  32'(m_tmo));
  endtask

  task automatic cyc(input bit im, input bit dm, input int r1, input int r2, input int d,
                     input bit mr, input bit br, input bit iq, input bit rt);
    drive(im, dm, r1, r2, d, mr, br, iq, rt);
    #4;
    step();
  endtask

  // Asynchronous reset applied mid-cycle, released away from the clock edge.
  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_timeout", 32'(tmo), 32'd0);
    chk("rst_cnt",     32'(scnt), 32'd0);
    chk("rst_pcw",     32'(pc_write), 32'(!(im_busy | dm_busy)));
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  int base;

  initial begin
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #2;
    chk("reset_pcw",    32'(pc_write), 32'd1);
    chk("reset_sel",    32'(pc_sel), 32'd0);
    chk("reset_stalls", 32'({st_memwb, st_exmem, st_idex, st_ifid}), 32'd0);
    chk("reset_flush",  32'({fl_exmem, fl_idex, fl_ifid}), 32'd0);
    chk("reset_cnt",    32'(scnt), 32'd0);
    chk("reset_tmo",    32'(tmo), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // T1 load-use: one bubble cycle only
    drive(0, 0, 1, 5, 5, 1, 0, 0, 0); #4;
    chk("t1_pcw", 32'(pc_write), 32'd0);
    chk("t1_stall_ifid", 32'(st_ifid), 32'd1);
    chk("t1_flush_idex", 32'(fl_idex), 32'd1);
    step();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // T2 load to x0: no hazard
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0); #4;
    chk("t2_pcw", 32'(pc_write), 32'd1);
    step();
    // T3 taken branch then kill cycle then idle
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0); #4;
    chk("t3_sel", 32'(pc_sel), 32'd1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #4;
    chk("t3_n1_flush", 32'({fl_exmem, fl_idex, fl_ifid}), 32'b001);
    step();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // T4 branch held across 4 memory-wait cycles
    base = int'(scnt);
    repeat (4) cyc(0, 1, 0, 0, 0, 0, 1, 0, 0);
    chk("t4_cnt_delta", 32'(int'(scnt) - base), 32'd4);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0); #4;
    chk("t4_sel", 32'(pc_sel), 32'd1);
    step();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // T5 mret beats irq and branch
    drive(0, 0, 0, 0, 0, 0, 1, 1, 1); #4;
    chk("t5_sel", 32'(pc_sel), 32'd3);
    chk("t5_flush_exmem", 32'(fl_exmem), 32'd1);
    step();
    // redirect followed by busy: kill owed until busy releases
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // T6 watchdog
    repeat (TO) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_timeout", 32'(tmo), 32'd1);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_sticky", 32'(tmo), 32'd1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    mid_reset();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          $urandom_range(0, 1) == 1, $urandom_range(0, 6) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
      if ($urandom_range(0, 299) == 0) begin
        drive($urandom_range(0, 1) == 1, 0, 0, 0, 0, 0, 0, 0, 0);
        mid_reset();
      end
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
